alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the accumulator datapath.
- Operand A comes from AC; operand B comes from the selected register.
- Single-cycle ops (add, xor, sub, shl) complete in one clock. Multiply, divide and modulo run as iterative engines under a start/busy/done handshake, so the control FSM stalls on busy instead of relying on fixed timing.
- The zero flag is derived from the newly produced result, never from the previous one.

Parameters:
- WIDTH, 16, operand and result width in bits (min 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only when busy=0.
- alu_op, input, 3, 0 nop, 1 add, 2 xor, 3 mul, 4 div, 5 mod, 6 shl1, 7 sub (A-B).
- in1, input, WIDTH, operand A (AC).
- in2, input, WIDTH, operand B (register).
- busy, output, 1, iterative op in progress.
- done, output, 1, one-cycle pulse; result valid.
- alu_out, output, WIDTH, result register.
- z, output, 1, alu_out==0 for the result delivered with done.
- div_err, output, 1, last div/mod had B==0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: alu_out=0, z=1, busy=0, done=0, div_err=0; FSM to IDLE; counter and internal regs cleared.
- Reset asserted mid-operation aborts the op immediately; no done pulse follows.
- FSM states: IDLE, CALC, FIN.
- Operand capture: when start=1 in IDLE at edge N, in1, in2 and alu_op are latched. Later changes on the inputs have no effect on the op in flight.
- Single-cycle ops (add, xor, sub, shl1, nop): result registered at edge N; done=1 during cycle N+1; FSM stays IDLE.
  - A new start may be accepted in cycle N+1, back to back.
- Iterative ops (mul, div, mod): IDLE->CALC at edge N; busy=1 from cycle N+1.
  - Exactly WIDTH iterations, one per clock.
  - CALC->FIN after the last iteration; result written at the FIN edge.
  - done=1 and busy=0 in cycle N+WIDTH+2; FSM returns to IDLE.
- Start while busy=1 is ignored. No queueing.
- Arithmetic (all modulo 2^WIDTH, unsigned):
  - add: carry discarded.
  - sub: wraps, e.g. 3-5 = 2^WIDTH-2.
  - shl1: (A<<1), MSB lost.
  - mul: shift-add; low WIDTH bits of the full product.
  - div/mod: restoring division; quotient or remainder.
- Divide by zero (B==0 for div or mod): no iteration. Handled like a single-cycle op with done at N+1.
  - div gives all-ones; mod gives A.
  - div_err=1.
- div_err: cleared by any other completed op, set only by div-by-zero. Updated together with done.
- nop: alu_out unchanged, z unchanged, done still pulses.
- z: computed combinationally from the next alu_out value and registered in the same edge, so z always matches the alu_out delivered with done.
- Outputs hold between operations; done is low except for the single completion cycle.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: mul uses a single-cycle combinational multiplier, done at N+1 like add; busy never asserts for mul. Div and mod remain iterative.
- Undefined: mul is iterative (WIDTH+2 cycle start-to-done) as above, and no hardware multiplier is inferred.

Test Plan:
- Reset then idle: after rst_n low->high, alu_out=0, z=1, busy=0, done=0, div_err=0. Asserting rst_n during CALC of a div returns the same values within the same cycle, with no done pulse.
- Add and sub (WIDTH=16):
  - start, op1, A=0xFFFF, B=0x0001 -> alu_out=0x0000, z=1, done at N+1.
  - Next cycle start, op7, A=3, B=5 -> alu_out=0xFFFE, z=0.
- Iterative mul (macro off): op3, A=300, B=300 -> busy high 17 cycles, done at N+18, alu_out=0x5F90 (90000 mod 65536). With ALU_FAST_MUL_EN: same value at N+1, busy never high.
- Div and mod:
  - op4, A=1000, B=7 -> alu_out=142, done at N+18.
  - op5, same operands -> alu_out=6.
  - op5, A=14, B=7 -> alu_out=0, z=1.
- Divide by zero: op4, A=0x1234, B=0 -> alu_out=0xFFFF, div_err=1, done at N+1. Following op1, A=1, B=1 -> alu_out=2, div_err=0.
- Handshake: start pulsed every cycle during a div with alu_op and operands changing -> only the first op completes, with the correct result. Inputs changed mid-CALC do not alter the result. nop after it leaves alu_out and z unchanged with one done pulse.

Source files
------------

// File: rtl/alu_mc_if.sv
// Operand/result bus of the multi-cycle ALU.
// Handshake: start is a request that is accepted only while busy=0; busy stays high while an
// iterative op runs; done is a one-cycle pulse marking alu_out, z and div_err as the new result.
interface alu_mc_if #(parameter int WIDTH = 16);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_out;
    logic             z;
    logic             div_err;

    modport master (
        output start, alu_op, in1, in2,
        input  busy, done, alu_out, z, div_err
    );

    modport slave (
        input  start, alu_op, in1, in2,
        output busy, done, alu_out, z, div_err
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU: single-cycle add/xor/sub/shl1, iterative mul/div/mod.
// ALU_FAST_MUL_EN: when defined, mul uses a combinational multiplier and completes in one cycle.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_mc_if.slave    bus,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SUB = 3'd7;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] alu_out_r;
    logic             z_r;
    logic             done_r;
    logic             err_r;

    logic             iter_req;
    logic             sc_err;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] fin_res;

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.alu_out = alu_out_r;
    assign bus.z       = z_r;
    assign bus.div_err = err_r;
    assign state_dbg   = state;

    // Decode of the op presented at the inputs; a zero divisor short-circuits to one cycle.
    always_comb begin
        sc_res   = alu_out_r;
        sc_err   = 1'b0;
        iter_req = 1'b0;
        case (bus.alu_op)
            OP_ADD: sc_res = bus.in1 + bus.in2;
            OP_XOR: sc_res = bus.in1 ^ bus.in2;
`ifdef ALU_FAST_MUL_EN
            OP_MUL: sc_res = bus.in1 * bus.in2;
`else
            OP_MUL: iter_req = 1'b1;
`endif
            OP_DIV: begin
                if (bus.in2 == '0) begin
                    sc_res = '1;
                    sc_err = 1'b1;
                end else begin
                    iter_req = 1'b1;
                end
            end
            OP_MOD: begin
                if (bus.in2 == '0) begin
                    sc_res = bus.in1;
                    sc_err = 1'b1;
                end else begin
                    iter_req = 1'b1;
                end
            end
            OP_SHL:  sc_res = {bus.in1[WIDTH-2:0], 1'b0};
            OP_SUB:  sc_res = bus.in1 - bus.in2;
            default: sc_res = alu_out_r;
        endcase
    end

    // Restoring division: acc is the partial remainder, sa shifts dividend out and quotient in.
    always_comb begin
        shifted = {acc, sa[WIDTH-1]};
        diff    = shifted - {1'b0, sb};
        mul_sum = acc + sa;
        fin_res = (op_q == OP_DIV) ? sa : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_NOP;
            acc       <= '0;
            sa        <= '0;
            sb        <= '0;
            alu_out_r <= '0;
            z_r       <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.alu_op;
                        if (iter_req) begin
                            state <= CALC;
                            cnt   <= '0;
                            acc   <= '0;
                            sa    <= bus.in1;
                            sb    <= bus.in2;
                        end else begin
                            alu_out_r <= sc_res;
                            z_r       <= (sc_res == '0);
                            err_r     <= sc_err;
                            done_r    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (op_q == OP_MUL) begin
                        if (sb[0]) acc <= mul_sum;
                        sa <= {sa[WIDTH-2:0], 1'b0};
                        sb <= {1'b0, sb[WIDTH-1:1]};
                    end else begin
                        acc <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        sa  <= {sa[WIDTH-2:0], ~diff[WIDTH]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    alu_out_r <= fin_res;
                    z_r       <= (fin_res == '0);
                    err_r     <= 1'b0;
                    done_r    <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed plan cases, back-to-back, handshake, reset abort, random ops.
module tb_alu_mc;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         n_cmp = 0;
    int         n_fail = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_out;
    logic         exp_z;
    logic         exp_err;
    int           exp_lat;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: plain unsigned arithmetic truncated to W bits.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = exp_out;
        exp_err = 1'b0;
        exp_lat = 1;
        case (op)
            3'd1: r = a + b;
            3'd2: r = a ^ b;
            3'd3: begin
                r = a * b;
`ifndef ALU_FAST_MUL_EN
                exp_lat = W + 2;
`endif
            end
            3'd4: if (b == 0) begin r = '1; exp_err = 1'b1; end
                  else begin r = a / b; exp_lat = W + 2; end
            3'd5: if (b == 0) begin r = a; exp_err = 1'b1; end
                  else begin r = a % b; exp_lat = W + 2; end
            3'd6: r = a << 1;
            3'd7: r = a - b;
            default: r = exp_out;
        endcase
        exp_out = r;
        exp_z = (r == 0);
        exp_q.push_back(r);
    endtask

    function automatic logic [W-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Issues one op, scrambles the inputs while it runs, returns what was seen at done.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt, output logic [W-1:0] out,
                         output logic zz, output logic err, output logic bsy);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.in1 = a; bus.in2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            bus.alu_op = 3'($urandom_range(0, 7));
            bus.in1 = W'($urandom);
            bus.in2 = W'($urandom);
            @(negedge clk);
            lat++;
        end
        out = bus.alu_out; zz = bus.z; err = bus.div_err; bsy = bus.busy;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.alu_op = '0; bus.in1 = '0; bus.in2 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.alu_out !== '0) begin n_fail++; $display("FAIL reset_out got %h exp 0", bus.alu_out); end
        n_cmp++; if (bus.z !== 1'b1) begin n_fail++; $display("FAIL reset_z got %b exp 1", bus.z); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_cmp++; if (bus.div_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.div_err); end
        exp_out = '0; exp_z = 1'b1; exp_err = 1'b0; exp_q.delete();
    endtask

    task automatic test_directed();
        logic [2:0]   t_op[10];
        logic [W-1:0] t_a[10];
        logic [W-1:0] t_b[10];
        logic [W-1:0] t_c[10];
        int lat, bcnt;
        logic [W-1:0] out, e;
        logic zz, err, bsy;
        t_op = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd5, 3'd4, 3'd1, 3'd2, 3'd6, 3'd5};
        t_a  = '{16'hFFFF, 16'd300, 16'd1000, 16'd1000, 16'd14, 16'h1234, 16'd1, 16'hA5A5, 16'h8001, 16'h1234};
        t_b  = '{16'h0001, 16'd300, 16'd7, 16'd7, 16'd7, 16'h0000, 16'd1, 16'h0F0F, 16'h5555, 16'h0000};
        t_c  = '{16'h0000, 16'h5F90, 16'd142, 16'd6, 16'd0, 16'hFFFF, 16'd2, 16'hAAAA, 16'h0002, 16'h1234};
        for (int i = 0; i < 10; i++) begin
            model(t_op[i], t_a[i], t_b[i]);
            do_op(t_op[i], t_a[i], t_b[i], lat, bcnt, out, zz, err, bsy);
            e = pop_exp();
            n_cmp++; if (out !== e) begin n_fail++; $display("FAIL dir_out[%0d] got %h exp %h", i, out, e); end
            n_cmp++; if (out !== t_c[i]) begin n_fail++; $display("FAIL dir_const[%0d] got %h exp %h", i, out, t_c[i]); end
            n_cmp++; if (zz !== exp_z) begin n_fail++; $display("FAIL dir_z[%0d] got %b exp %b", i, zz, exp_z); end
            n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL dir_err[%0d] got %b exp %b", i, err, exp_err); end
            n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL dir_lat[%0d] got %0d exp %0d", i, lat, exp_lat); end
            n_cmp++; if (bcnt != exp_lat - 1) begin n_fail++; $display("FAIL dir_busy_cycles[%0d] got %0d exp %0d", i, bcnt, exp_lat - 1); end
            n_cmp++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL dir_busy_at_done[%0d] got %b exp 0", i, bsy); end
            @(negedge clk);
            n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d] got %b exp 0", i, bus.done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 3'd1; bus.in1 = 16'hFFFF; bus.in2 = 16'h0001;
        model(3'd1, 16'hFFFF, 16'h0001);
        @(negedge clk);
        e = pop_exp();
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got %b exp 1", bus.done); end
        n_cmp++; if (bus.alu_out !== e) begin n_fail++; $display("FAIL b2b_out1 got %h exp %h", bus.alu_out, e); end
        n_cmp++; if (bus.z !== 1'b1) begin n_fail++; $display("FAIL b2b_z1 got %b exp 1", bus.z); end
        bus.alu_op = 3'd7; bus.in1 = 16'd3; bus.in2 = 16'd5;
        model(3'd7, 16'd3, 16'd5);
        @(negedge clk);
        bus.start = 1'b0;
        e = pop_exp();
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %b exp 1", bus.done); end
        n_cmp++; if (bus.alu_out !== e) begin n_fail++; $display("FAIL b2b_out2 got %h exp %h", bus.alu_out, e); end
        n_cmp++; if (bus.alu_out !== 16'hFFFE) begin n_fail++; $display("FAIL b2b_const2 got %h exp fffe", bus.alu_out); end
        n_cmp++; if (bus.z !== 1'b0) begin n_fail++; $display("FAIL b2b_z2 got %b exp 0", bus.z); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_low got %b exp 0", bus.done); end
    endtask

    task automatic test_handshake();
        int lat, bcnt, extra;
        logic [W-1:0] e, out_before;
        logic z_before, zz, err, bsy;
        logic [W-1:0] out;
        model(3'd4, 16'd1000, 16'd7);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 3'd4; bus.in1 = 16'd1000; bus.in2 = 16'd7;
        @(negedge clk);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            bus.start = (bus.busy === 1'b1);
            bus.alu_op = 3'($urandom_range(0, 7));
            bus.in1 = W'($urandom);
            bus.in2 = W'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        e = pop_exp();
        n_cmp++; if (bus.alu_out !== e) begin n_fail++; $display("FAIL hs_out got %h exp %h", bus.alu_out, e); end
        n_cmp++; if (lat != W + 2) begin n_fail++; $display("FAIL hs_lat got %0d exp %0d", lat, W + 2); end
        extra = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL hs_extra_activity got %0d exp 0", extra); end
        out_before = exp_out; z_before = exp_z;
        model(3'd0, 16'h1111, 16'h2222);
        do_op(3'd0, 16'h1111, 16'h2222, lat, bcnt, out, zz, err, bsy);
        e = pop_exp();
        n_cmp++; if (out !== out_before || out !== e) begin n_fail++; $display("FAIL nop_out got %h exp %h", out, out_before); end
        n_cmp++; if (zz !== z_before) begin n_fail++; $display("FAIL nop_z got %b exp %b", zz, z_before); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL nop_lat got %0d exp 1", lat); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL nop_done_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 3'd4; bus.in1 = 16'd5000; bus.in2 = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before got %b exp 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b exp 0", bus.done); end
        n_cmp++; if (bus.alu_out !== '0) begin n_fail++; $display("FAIL rst_mid_out got %h exp 0", bus.alu_out); end
        n_cmp++; if (bus.z !== 1'b1) begin n_fail++; $display("FAIL rst_mid_z got %b exp 1", bus.z); end
        n_cmp++; if (bus.div_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %b exp 0", bus.div_err); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d exp 0", state_dbg); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d exp 0", pulses); end
        exp_out = '0; exp_z = 1'b1; exp_err = 1'b0; exp_q.delete();
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [W-1:0] a, b, out, e;
        logic [2:0] op;
        logic zz, err, bsy;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            model(op, a, b);
            do_op(op, a, b, lat, bcnt, out, zz, err, bsy);
            e = pop_exp();
            n_cmp++; if (out !== e) begin n_fail++; $display("FAIL rnd_out[%0d] op %0d a %h b %h got %h exp %h", i, op, a, b, out, e); end
            n_cmp++; if (zz !== exp_z) begin n_fail++; $display("FAIL rnd_z[%0d] got %b exp %b", i, zz, exp_z); end
            n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b exp %b", i, err, exp_err); end
            n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d] got %0d exp %0d", i, lat, exp_lat); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_handshake();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
